// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU operations, datapath select values and trap causes.
package cpu_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5,
    S_MULDIV = 3'd6
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // alt selects sub/sra; callers pass it only where the encoding allows it
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation: maps RV32I branch func3 and the ALU compare
// flags to a taken bit. Unused func3 codes never take.
module branch_eval (
  input  logic [2:0] func3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o
);

  always_comb begin
    case (func3_i)
      3'b000:  taken_o = zero_i;
      3'b001:  taken_o = !zero_i;
      3'b100:  taken_o = lt_i;
      3'b101:  taken_o = !lt_i;
      3'b110:  taken_o = ltu_i;
      3'b111:  taken_o = !ltu_i;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a memory
// wait timeout. Define MULDIV_EN to add RV32M sequencing via a MULDIV state.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int WAIT_W     = 5,
  parameter int ALU_CTR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 alu_ltu,
  input  logic                 mem_ready,
`ifdef MULDIV_EN
  input  logic                 muldiv_done,
  output logic                 muldiv_start,
`endif
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic [2:0]           rw_type,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [1:0]           alusrc_a,
  output logic [1:0]           alusrc_b,
  output logic [ALU_CTR_W-1:0] alu_ctr,
  output logic                 regwrite,
  output logic [1:0]           wb_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_o
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       legal, taken;
  logic [1:0] dec_a, dec_b;
  logic [3:0] dec_op, alu_op;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign f7          = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  branch_eval u_branch (
    .func3_i (f3),
    .zero_i  (alu_zero),
    .lt_i    (alu_lt),
    .ltu_i   (alu_ltu),
    .taken_o (taken)
  );

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OPC_OP:     legal = (f7 == 7'b0000000) ||
                          (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
`ifdef MULDIV_EN
                          || (f7 == 7'b0000001)
`endif
                          ;
      OPC_OPIMM:  if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                  else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      OPC_LOAD:   legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  legal = !f3[2] && (f3 != 3'b011);
      OPC_BRANCH: legal = (f3[2:1] != 2'b01);
      OPC_JALR:   legal = (f3 == 3'b000);
      OPC_JAL, OPC_LUI, OPC_AUIPC: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  // ALU operand/op selection; held from EXEC through WB so results stay stable
  always_comb begin
    dec_a  = A_RS1;
    dec_b  = B_RS2;
    dec_op = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec_op = alu_decode(f3, f7[5]);
`ifdef MULDIV_EN
        if (f7 == 7'b0000001) dec_op = ALU_ADD;
`endif
      end
      OPC_OPIMM: begin
        dec_b  = B_IMM;
        dec_op = alu_decode(f3, (f3 == 3'b101) && f7[5]);
      end
      OPC_LUI:                       begin dec_a = A_ZERO; dec_b = B_IMM; end
      OPC_AUIPC, OPC_JAL:            begin dec_a = A_PC;   dec_b = B_IMM; end
      OPC_LOAD, OPC_STORE, OPC_JALR: dec_b = B_IMM;
      OPC_BRANCH:                    dec_op = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    rw_type  = 3'b000;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_PLUS4;
    alusrc_a = A_RS1;
    alusrc_b = B_RS2;
    alu_op   = ALU_ADD;
    regwrite = 1'b0;
    wb_sel   = WB_ALU;
`ifdef MULDIV_EN
    muldiv_start = 1'b0;
`endif
    state_d  = state_q;
    cause_d  = cause_q;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          alusrc_a = A_PC;
          alusrc_b = B_FOUR;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (legal) state_d = S_EXEC;
          else begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          alusrc_a = dec_a;
          alusrc_b = dec_b;
          alu_op   = dec_op;
          case (opcode)
            OPC_LOAD, OPC_STORE: state_d = S_MEM;
            OPC_BRANCH: begin
              pc_we   = taken;
              pc_src  = taken ? PC_BRANCH : PC_PLUS4;
              state_d = S_FETCH;
            end
            OPC_JAL:  begin pc_we = 1'b1; pc_src = PC_BRANCH; state_d = S_WB; end
            OPC_JALR: begin pc_we = 1'b1; pc_src = PC_JALR;   state_d = S_WB; end
            default:  state_d = S_WB;
          endcase
`ifdef MULDIV_EN
          if (opcode == OPC_OP && f7 == 7'b0000001) begin
            muldiv_start = 1'b1;
            state_d      = S_MULDIV;
          end
`endif
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OPC_STORE);
          rw_type  = f3;
          alusrc_a = dec_a;
          alusrc_b = dec_b;
          alu_op   = dec_op;
          if (mem_ready) state_d = (opcode == OPC_LOAD) ? S_WB : S_FETCH;
          else if (wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
          end
        end
        S_WB: begin
          regwrite = 1'b1;
          alusrc_a = dec_a;
          alusrc_b = dec_b;
          alu_op   = dec_op;
          case (opcode)
            OPC_LOAD:          wb_sel = WB_MEM;
            OPC_JAL, OPC_JALR: wb_sel = WB_PC4;
            default:           wb_sel = WB_ALU;
          endcase
          state_d = S_FETCH;
        end
`ifdef MULDIV_EN
        S_MULDIV: if (muldiv_done) state_d = S_WB;
`endif
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Counts unanswered request cycles; any state change or completion restarts it
  always_comb begin
    if (state_d != state_q || mem_ready) wait_d = '0;
    else if (mem_req)                    wait_d = wait_q + WAIT_W'(1);
    else                                 wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  assign alu_ctr    = ALU_CTR_W'(alu_op);
  assign trap       = !rst && (state_q == S_TRAP);
  assign trap_cause = rst ? CAUSE_NONE : cause_q;
  assign state_o    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction table walked through
// FETCH/DECODE/EXEC plus hand sequences for waits, timeouts, traps and reset.
module tb_multicycle_control;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3;
  localparam int ST_WB = 4, ST_TRAP = 5, ST_MULDIV = 6;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h0000A203;
  localparam logic [31:0] I_SW  = 32'h0020A023;
  localparam logic [31:0] I_BAD = 32'h0000007F;
  localparam logic [31:0] I_MUL = 32'h022081B3;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, regwrite, trap;
  logic [2:0]  rw_type, state_o;
  logic [1:0]  pc_src, alusrc_a, alusrc_b, wb_sel, trap_cause;
  logic [3:0]  alu_ctr;
`ifdef MULDIV_EN
  logic        muldiv_done = 1'b0, muldiv_start;
`endif
  logic [2:0]  be_f3 = '0;
  logic        be_z = 1'b0, be_lt = 1'b0, be_ltu = 1'b0, be_taken;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_LIMIT(16), .WAIT_W(5), .ALU_CTR_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .alu_ltu(alu_ltu), .mem_ready(mem_ready),
`ifdef MULDIV_EN
    .muldiv_done(muldiv_done), .muldiv_start(muldiv_start),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .rw_type(rw_type),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alusrc_a(alusrc_a),
    .alusrc_b(alusrc_b), .alu_ctr(alu_ctr), .regwrite(regwrite), .wb_sel(wb_sel),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  branch_eval u_be (
    .func3_i(be_f3), .zero_i(be_z), .lt_i(be_lt), .ltu_i(be_ltu), .taken_o(be_taken)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [2:0]  flags;   // {zero, lt, ltu}
    int          dec_nxt;
    int          ex_nxt;
    logic        pcwe;
    logic [1:0]  pcsrc;
    logic [3:0]  alu;
    logic [1:0]  a, b, wb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [31:0] i, logic [2:0] fl, int dn, int en,
                              logic pw, logic [1:0] ps, logic [3:0] al,
                              logic [1:0] a, logic [1:0] b, logic [1:0] wb);
    vec_t v;
    v.name = n; v.ins = i; v.flags = fl; v.dec_nxt = dn; v.ex_nxt = en;
    v.pcwe = pw; v.pcsrc = ps; v.alu = al; v.a = a; v.b = b; v.wb = wb;
    return v;
  endfunction

  function automatic vec_t ill(string n, logic [31:0] i);
    return mk(n, i, 3'b000, ST_TRAP, ST_TRAP, 1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 32'({mem_req, mem_we, addr_sel, rw_type, ir_we, pc_we, pc_src, alusrc_a,
                   alusrc_b, alu_ctr, regwrite, wb_sel, trap, trap_cause, state_o}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    vec_t v;
    int cyc, rw, cnt, starts;
    logic [11:0] seq;
    logic exp_t;

    vecs.push_back(mk("add",   I_ADD,        3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("sub",   32'h402081B3, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("sra",   32'h4020D1B3, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd7, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("and",   32'h0020F1B3, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd9, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("addi",  32'h00500093, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd0, 2'd0, 2'd1, 2'd0));
    vecs.push_back(mk("srai",  32'h40315093, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd7, 2'd0, 2'd1, 2'd0));
    vecs.push_back(mk("lui",   32'h123452B7, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd0, 2'd2, 2'd1, 2'd0));
    vecs.push_back(mk("auipc", 32'h00001117, 3'b000, ST_EXEC, ST_WB,    1'b0, 2'd0, 4'd0, 2'd1, 2'd1, 2'd0));
    vecs.push_back(mk("beq_t", 32'h00208463, 3'b100, ST_EXEC, ST_FETCH, 1'b1, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("beq_n", 32'h00208463, 3'b000, ST_EXEC, ST_FETCH, 1'b0, 2'd0, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("bne_t", 32'h00209463, 3'b000, ST_EXEC, ST_FETCH, 1'b1, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("blt_t", 32'h0020C463, 3'b010, ST_EXEC, ST_FETCH, 1'b1, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("bge_n", 32'h0020D463, 3'b010, ST_EXEC, ST_FETCH, 1'b0, 2'd0, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("bltu_t",32'h0020E463, 3'b001, ST_EXEC, ST_FETCH, 1'b1, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("bgeu_t",32'h0020F463, 3'b000, ST_EXEC, ST_FETCH, 1'b1, 2'd1, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("bgeu_n",32'h0020F463, 3'b001, ST_EXEC, ST_FETCH, 1'b0, 2'd0, 4'd1, 2'd0, 2'd0, 2'd0));
    vecs.push_back(mk("jal",   32'h010000EF, 3'b000, ST_EXEC, ST_WB,    1'b1, 2'd1, 4'd0, 2'd1, 2'd1, 2'd2));
    vecs.push_back(mk("jalr",  32'h000280E7, 3'b000, ST_EXEC, ST_WB,    1'b1, 2'd2, 4'd0, 2'd0, 2'd1, 2'd2));
    vecs.push_back(ill("opc7f",    I_BAD));
    vecs.push_back(ill("sll_f7",   32'h402091B3));
    vecs.push_back(ill("br_f3_2",  32'h0020A463));
    vecs.push_back(ill("jalr_f3",  32'h000290E7));
    vecs.push_back(ill("ld_f3_3",  32'h0000B203));
`ifndef MULDIV_EN
    vecs.push_back(ill("mul_nomd", I_MUL));
`endif

    // reset state
    step();
    step();
    #1;
    chk_quiet("reset outputs");
    rst = 1'b0;
    #1;
    chk("post-reset state", 32'(state_o), ST_FETCH);
    chk("post-reset mem_req", 32'(mem_req), 32'd1);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_reset();
      instr = v.ins;
      {alu_zero, alu_lt, alu_ltu} = v.flags;
      mem_ready = 1'b1;
      #1;
      chk({v.name, " fetch ir_we"}, 32'(ir_we), 32'd1);
      step();
      mem_ready = 1'b0;
      #1;
      chk({v.name, " decode state"}, 32'(state_o), ST_DECODE);
      chk({v.name, " decode pc_we"}, 32'(pc_we), 32'd0);
      step();
      #1;
      chk({v.name, " after decode"}, 32'(state_o), 32'(v.dec_nxt));
      if (v.dec_nxt == ST_TRAP) begin
        chk({v.name, " trap"}, 32'(trap), 32'd1);
        chk({v.name, " trap_cause"}, 32'(trap_cause), 32'd1);
      end else begin
        chk({v.name, " pc_we"}, 32'(pc_we), 32'(v.pcwe));
        chk({v.name, " pc_src"}, 32'(pc_src), 32'(v.pcsrc));
        chk({v.name, " alu_ctr"}, 32'(alu_ctr), 32'(v.alu));
        chk({v.name, " alusrc_a"}, 32'(alusrc_a), 32'(v.a));
        chk({v.name, " alusrc_b"}, 32'(alusrc_b), 32'(v.b));
        step();
        #1;
        chk({v.name, " after exec"}, 32'(state_o), 32'(v.ex_nxt));
        if (v.ex_nxt == ST_WB) begin
          chk({v.name, " regwrite"}, 32'(regwrite), 32'd1);
          chk({v.name, " wb_sel"}, 32'(wb_sel), 32'(v.wb));
        end
      end
    end
    {alu_zero, alu_lt, alu_ltu} = 3'b000;

    // add with immediate memory: FETCH, DECODE, EXEC, WB then back to FETCH
    do_reset();
    instr = I_ADD;
    mem_ready = 1'b1;
    #1;
    cyc = 0; rw = 0; seq = '0;
    do begin
      seq = {seq[8:0], state_o};
      rw += int'(regwrite);
      step();
      #1;
      cyc++;
    end while (state_o != 3'(ST_FETCH) && cyc < 20);
    chk("add cycles", 32'(cyc), 32'd4);
    chk("add regwrite cycles", 32'(rw), 32'd1);
    chk("add state seq", 32'(seq), 32'h054);

    // lw: fetch ready on 3rd cycle, data ready on 5th
    do_reset();
    instr = I_LW;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #1;
      chk("lw fetch mem_req", 32'(mem_req), 32'd1);
      chk("lw fetch ir_we", 32'(ir_we), 32'(k == 2));
      step();
    end
    mem_ready = 1'b0;
    step();
    #1;
    chk("lw exec state", 32'(state_o), ST_EXEC);
    chk("lw exec alusrc_b", 32'(alusrc_b), 32'd1);
    chk("lw exec alu_ctr", 32'(alu_ctr), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      mem_ready = (k == 4);
      #1;
      chk("lw mem state", 32'(state_o), ST_MEM);
      chk("lw mem_req", 32'(mem_req), 32'd1);
      chk("lw addr_sel", 32'(addr_sel), 32'd1);
      chk("lw mem_we", 32'(mem_we), 32'd0);
      chk("lw rw_type", 32'(rw_type), 32'd2);
      step();
    end
    mem_ready = 1'b0;
    #1;
    chk("lw wb state", 32'(state_o), ST_WB);
    chk("lw wb_sel", 32'(wb_sel), 32'd1);
    chk("lw regwrite", 32'(regwrite), 32'd1);
    chk("lw trap", 32'(trap), 32'd0);
    step();
    #1;
    chk("lw back to fetch", 32'(state_o), ST_FETCH);

    // store never answered: exactly 16 request cycles in MEM, then timeout trap
    do_reset();
    instr = I_SW;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    #1;
    chk("sw mem state", 32'(state_o), ST_MEM);
    chk("sw mem_we", 32'(mem_we), 32'd1);
    cnt = 0;
    while (state_o == 3'(ST_MEM) && cnt < 40) begin
      if (mem_req) cnt++;
      step();
      #1;
    end
    chk("sw wait cycles", 32'(cnt), 32'd16);
    chk("sw trap", 32'(trap), 32'd1);
    chk("sw trap_cause", 32'(trap_cause), 32'd2);
    chk("sw trap mem_req", 32'(mem_req), 32'd0);
    chk("sw trap mem_we", 32'(mem_we), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("trap ignores ready", 32'(mem_req | ir_we | pc_we), 32'd0);
    step();
    step();
    #1;
    chk("trap held", 32'(state_o), ST_TRAP);
    mem_ready = 1'b0;

    // fetch ready on the cycle the counter would expire: ready wins
    do_reset();
    instr = I_ADD;
    for (int k = 0; k < 16; k++) begin
      mem_ready = (k == 15);
      step();
    end
    mem_ready = 1'b0;
    #1;
    chk("late ready decode", 32'(state_o), ST_DECODE);
    chk("late ready no trap", 32'(trap), 32'd0);

    // fetch never answered: timeout
    do_reset();
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("fetch wait mem_req", 32'(mem_req), 32'd1);
      step();
    end
    #1;
    chk("fetch timeout state", 32'(state_o), ST_TRAP);
    chk("fetch timeout cause", 32'(trap_cause), 32'd2);

    // illegal opcode, then reset out of TRAP
    do_reset();
    instr = I_BAD;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    #1;
    chk("illegal trap", 32'(trap), 32'd1);
    chk("illegal cause", 32'(trap_cause), 32'd1);
    rst = 1'b1;
    #1;
    chk_quiet("rst over trap");
    step();
    #1;
    chk_quiet("rst held");
    rst = 1'b0;
    #1;
    chk("rst release state", 32'(state_o), ST_FETCH);
    chk("rst release trap", 32'({trap, trap_cause}), 32'd0);

    // reset in the middle of a store: request dropped, no commit
    do_reset();
    instr = I_SW;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    #1;
    chk("sw2 mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rst mid-mem req/we", 32'({mem_req, mem_we}), 32'd0);
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst mid-mem state", 32'(state_o), ST_FETCH);

`ifdef MULDIV_EN
    do_reset();
    instr = I_MUL;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    #1;
    chk("mul exec state", 32'(state_o), ST_EXEC);
    chk("mul start pulse", 32'(muldiv_start), 32'd1);
    step();
    starts = 0;
    for (int k = 0; k < 7; k++) begin
      muldiv_done = (k == 6);
      #1;
      chk("mul wait state", 32'(state_o), ST_MULDIV);
      starts += int'(muldiv_start);
      step();
    end
    muldiv_done = 1'b0;
    #1;
    chk("mul extra starts", 32'(starts), 32'd0);
    chk("mul wb state", 32'(state_o), ST_WB);
    chk("mul regwrite", 32'(regwrite), 32'd1);
`endif

    // branch_eval standalone against the branch truth table
    for (int f = 0; f < 8; f++) begin
      for (int m = 0; m < 8; m++) begin
        be_f3 = 3'(f);
        {be_z, be_lt, be_ltu} = 3'(m);
        #1;
        case (f)
          0:       exp_t = be_z;
          1:       exp_t = !be_z;
          4:       exp_t = be_lt;
          5:       exp_t = !be_lt;
          6:       exp_t = be_ltu;
          7:       exp_t = !be_ltu;
          default: exp_t = 1'b0;
        endcase
        chk("branch_eval taken", 32'(be_taken), 32'(exp_t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequential successor to the single-cycle combinational decoder.
- Drives a shared-memory, multi-cycle RV32I datapath through FETCH/DECODE/EXEC/MEM/WB.
- Waits on a variable-latency memory handshake and evaluates branch conditions internally.
- Raises a trap on illegal instructions or memory timeout.
- Sits between the instruction register/ALU flags and every datapath enable/select.

Parameters:
- WAIT_LIMIT, 16: maximum cycles mem_req may stay high without mem_ready before a timeout trap; must be >= 2.
- WAIT_W, 5: width of the wait counter; must hold WAIT_LIMIT.
- ALU_CTR_W, 4: width of alu_ctr.

Ports:
- clk  in  1  system clock; one clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr  in  32  instruction register contents; valid from DECODE onward.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed A < B.
- alu_ltu  in  1  unsigned A < B.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  store request; valid only while mem_req = 1.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- rw_type  out  3  load/store size and sign (func3).
- ir_we  out  1  latch instr from memory.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 = PC+4, 1 = branch/jal target, 2 = jalr target (LSB cleared).
- alusrc_a  out  2  0 = rs1, 1 = PC, 2 = zero (lui).
- alusrc_b  out  2  0 = rs2, 1 = immediate, 2 = constant 4.
- alu_ctr  out  ALU_CTR_W  ALU operation.
- regwrite  out  1  register file write enable.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 = none, 1 = illegal, 2 = memory timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- Reset:
  - While rst = 1, all outputs are 0 and the wait counter is 0.
  - In the first cycle after rst falls, state = FETCH.
- FETCH:
  - Outputs: mem_req = 1, addr_sel = 0.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_src = 0; go to DECODE.
  - Minimum fetch latency is 1 cycle.
- DECODE:
  - Classify the opcode.
  - Unknown opcode, or a func3/func7 combination not in RV32I: go to TRAP with cause 1.
  - Otherwise go to EXEC.
  - No datapath writes in this state.
- EXEC:
  - alu_ctr is decoded from opcode/func3/func7.
  - R-type and I-type ALU instructions, lui, auipc: go to WB.
  - Load/store: alu_ctr = add, alusrc_b = 1; go to MEM.
  - Branches:
    - beq: taken when alu_zero.
    - bne: taken when !alu_zero.
    - blt: taken when alu_lt.
    - bge: taken when !alu_lt.
    - bltu: taken when alu_ltu.
    - bgeu: taken when !alu_ltu.
    - If taken, pc_we = 1 and pc_src = 1.
    - Go to FETCH; total 3 cycles plus fetch wait.
  - jal/jalr: pc_we = 1, pc_src = 1 or 2; go to WB with wb_sel = 2.
- MEM:
  - Outputs: mem_req = 1, addr_sel = 1, mem_we = store, rw_type = func3.
  - On mem_ready: load goes to WB with wb_sel = 1; store goes to FETCH.
- WB: regwrite = 1 for one cycle, then FETCH. Writes to rd = x0 are still issued; the register file ignores them.
- Wait counter:
  - Increments every cycle in which mem_req = 1 and mem_ready = 0.
  - Clears on mem_ready and on every state change.
  - Reaching WAIT_LIMIT: go to TRAP with cause 2; mem_req drops the same cycle the state changes.
- TRAP:
  - trap = 1; all enables are 0.
  - Held until rst; no further fetches.
  - A mem_ready arriving in the TRAP cycle is ignored.
- Simultaneous events:
  - mem_ready in the same cycle the counter would hit WAIT_LIMIT: mem_ready wins, no trap.
  - rst mid-MEM: the request is abandoned and no store is committed.
- No output is ever X after reset. alu_ctr = 0 (add) in states that do not use the ALU.

Optional Feature:
- Macro: MULDIV_EN.
- Defined:
  - OP with func7 = 0000001 decodes as RV32M.
  - Adds input muldiv_done, output muldiv_start, and state MULDIV.
  - EXEC pulses muldiv_start for one cycle, then enters MULDIV.
  - MULDIV waits for muldiv_done with no timeout, then goes to WB.
- Undefined: that encoding traps with illegal-instruction cause 1; the extra ports are absent.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams;
  - the state encoding;
  - alu_ctr codes;
  - pc_src, wb_sel and alusrc select encodings;
  - trap cause codes.
- One sub-module, branch_eval: combinational mapping of func3 and the three flags to a taken bit. It is tested standalone.

Test Plan:
- add x3,x1,x2 with mem_ready asserted immediately -> states FETCH, DECODE, EXEC, WB; regwrite for exactly 1 cycle; 4 cycles total.
- lw with fetch ready after 3 cycles and data ready after 5 -> mem_req held throughout each wait; wb_sel = 1; rw_type = 010; no trap.
- beq with alu_zero = 1, then with alu_zero = 0 -> pc_we/pc_src = 1 in EXEC, then pc_we = 0 in EXEC; bltu checked with alu_ltu = 1.
- Store with mem_ready never asserted, WAIT_LIMIT = 16 -> trap = 1 and trap_cause = 2 at cycle 16 of MEM; mem_we is never committed.
- Opcode 7'b1111111 -> trap_cause = 1 after DECODE; rst asserted then released -> all outputs 0 during reset, FETCH the next cycle.
- MULDIV_EN: mul with muldiv_done after 7 cycles -> single muldiv_start pulse, then WB. Without the macro the same encoding -> illegal trap.
